// File: rtl/major_vote_seq.sv
// Sequential majority voter: accumulates up to K labels into a per-class
// histogram, scans it one class per cycle, and returns the winning label,
// its vote count, a tie flag and an out-of-range flag over valid/ready.
module major_vote_seq #(
  parameter int unsigned LABEL_W     = 2,
  parameter int unsigned NUM_CLASSES = 4,
  parameter int unsigned K           = 5,
  parameter int unsigned CNT_W       = $clog2(K + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LABEL_W-1:0] in_label,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] out_label,
  output logic [CNT_W-1:0]   out_votes,
  output logic               out_tie,
  output logic               out_bad
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hist_q [NUM_CLASSES];
  logic [CNT_W-1:0]   hist_d [NUM_CLASSES];
  logic [CNT_W-1:0]   vote_cnt_q, vote_cnt_d;
  logic               bad_q, bad_d;
  logic [LABEL_W-1:0] scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0]   best_q, best_d;
  logic [LABEL_W-1:0] best_idx_q, best_idx_d;
  logic               tie_q, tie_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [LABEL_W-1:0] out_label_q, out_label_d;
  logic [CNT_W-1:0]   out_votes_q, out_votes_d;
  logic               out_tie_q, out_tie_d;
  logic               out_bad_q, out_bad_d;

  // Histogram bin selected by the scan index and in-range detection of the incoming label
  logic [CNT_W-1:0]   cur_cnt;
  logic               label_in_range;

  always_comb begin
    cur_cnt        = '0;
    label_in_range = 1'b0;
    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
      if (scan_idx_q == LABEL_W'(c)) cur_cnt = hist_q[c];
      if (in_label == LABEL_W'(c))   label_in_range = 1'b1;
    end
  end

  // Next-state and next-register logic for the ACCUM -> SCAN -> DONE sequence
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    vote_cnt_d  = vote_cnt_q;
    bad_d       = bad_q;
    scan_idx_d  = scan_idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    tie_d       = tie_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_label_d = out_label_q;
    out_votes_d = out_votes_q;
    out_tie_d   = out_tie_q;
    out_bad_d   = out_bad_q;

    unique case (state_q)
      ST_ACCUM: begin
        if (in_valid && in_ready_q) begin
          for (int c = 0; c < int'(NUM_CLASSES); c++) begin
            if (in_label == LABEL_W'(c)) hist_d[c] = hist_q[c] + CNT_W'(1);
          end
          if (!label_in_range) bad_d = 1'b1;
          vote_cnt_d = vote_cnt_q + CNT_W'(1);
          // The K-th vote closes the decision even without in_last
          if (in_last || (vote_cnt_q == CNT_W'(K - 1))) begin
            state_d    = ST_SCAN;
            scan_idx_d = '0;
            in_ready_d = 1'b0;
          end
        end
      end

      ST_SCAN: begin
        if (scan_idx_q == '0) begin
          best_d     = cur_cnt;
          best_idx_d = '0;
          tie_d      = 1'b0;
        end else if (cur_cnt > best_q) begin
          best_d     = cur_cnt;
          best_idx_d = scan_idx_q;
          tie_d      = 1'b0;
        end else if (cur_cnt == best_q) begin
          tie_d      = 1'b1;
        end
        if (scan_idx_q == LABEL_W'(NUM_CLASSES - 1)) begin
          state_d = ST_DONE;
        end else begin
          scan_idx_d = scan_idx_q + LABEL_W'(1);
        end
      end

      ST_DONE: begin
        // First DONE cycle publishes the scan result; later cycles wait for the consumer
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_label_d = best_idx_q;
          out_votes_d = best_q;
          out_tie_d   = tie_q;
          out_bad_d   = bad_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          for (int c = 0; c < int'(NUM_CLASSES); c++) hist_d[c] = '0;
          vote_cnt_d  = '0;
          bad_d       = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_ACCUM;
        end
      end

      default: begin
        state_d    = ST_ACCUM;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_ACCUM;
      for (int c = 0; c < int'(NUM_CLASSES); c++) hist_q[c] <= '0;
      vote_cnt_q  <= '0;
      bad_q       <= 1'b0;
      scan_idx_q  <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      tie_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_label_q <= '0;
      out_votes_q <= '0;
      out_tie_q   <= 1'b0;
      out_bad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      vote_cnt_q  <= vote_cnt_d;
      bad_q       <= bad_d;
      scan_idx_q  <= scan_idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      tie_q       <= tie_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_label_q <= out_label_d;
      out_votes_q <= out_votes_d;
      out_tie_q   <= out_tie_d;
      out_bad_q   <= out_bad_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_label = out_label_q;
  assign out_votes = out_votes_q;
  assign out_tie   = out_tie_q;
  assign out_bad   = out_bad_q;

endmodule

// File: tb/tb_major_vote_seq.sv
// Scoreboard bench for major_vote_seq: one 4-class and one 3-class instance.
module tb_major_vote_seq;

  typedef struct packed {
    logic [1:0] label;
    logic [2:0] votes;
    logic       tie;
    logic       bad;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] lab = '0;
  logic       last = 1'b0;

  logic       iv4 = 1'b0, ordy4 = 1'b1;
  logic       rdy4, ov4, tie4, bad4;
  logic [1:0] ol4;
  logic [2:0] ovt4;

  logic       iv3 = 1'b0, ordy3 = 1'b1;
  logic       rdy3, ov3, tie3, bad3;
  logic [1:0] ol3;
  logic [2:0] ovt3;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q4 [$];
  exp_t q3 [$];

  major_vote_seq #(.LABEL_W(2), .NUM_CLASSES(4), .K(5)) dut (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .in_label(lab),
    .in_last(last), .out_valid(ov4), .out_ready(ordy4), .out_label(ol4),
    .out_votes(ovt4), .out_tie(tie4), .out_bad(bad4));

  major_vote_seq #(.LABEL_W(2), .NUM_CLASSES(3), .K(5)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(rdy3), .in_label(lab),
    .in_last(last), .out_valid(ov3), .out_ready(ordy3), .out_label(ol3),
    .out_votes(ovt3), .out_tie(tie3), .out_bad(bad3));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor for the 4-class instance: compare every valid cycle, pop on handshake
  always @(negedge clk) begin
    exp_t m;
    if (rst && ov4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out4: got label %0d with no expected result", ol4);
      end else begin
        chk("out4_label", ol4, q4[0].label);
        chk("out4_votes", ovt4, q4[0].votes);
        chk("out4_tie", tie4, q4[0].tie);
        chk("out4_bad", bad4, q4[0].bad);
        if (ordy4) m = q4.pop_front();
      end
    end
  end

  // Monitor for the 3-class instance
  always @(negedge clk) begin
    exp_t m;
    if (rst && ov3) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out3: got label %0d with no expected result", ol3);
      end else begin
        chk("out3_label", ol3, q3[0].label);
        chk("out3_votes", ovt3, q3[0].votes);
        chk("out3_tie", tie3, q3[0].tie);
        chk("out3_bad", bad3, q3[0].bad);
        if (ordy3) m = q3.pop_front();
      end
    end
  end

  function automatic logic rdy_of(int d);
    return (d == 4) ? rdy4 : rdy3;
  endfunction

  function automatic logic ov_of(int d);
    return (d == 4) ? ov4 : ov3;
  endfunction

  task automatic send(int d, logic [1:0] l, logic lst);
    int n = 0;
    @(negedge clk);
    lab  = l;
    last = lst;
    if (d == 4) iv4 = 1'b1; else iv3 = 1'b1;
    while (!rdy_of(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for 100 cycles");
    end
    @(posedge clk);
    #1;
    iv4  = 1'b0;
    iv3  = 1'b0;
    last = 1'b0;
  endtask

  // Send n votes (first vote in the top bits of v); in_last on the final one if use_last
  task automatic run_vec(int d, logic [9:0] v, int n, bit use_last, exp_t e);
    int t;
    int w = 0;
    if (d == 4) q4.push_back(e); else q3.push_back(e);
    for (int i = 0; i < n; i++) begin
      send(d, v[9-2*i -: 2], (use_last && i == n - 1) ? 1'b1 : 1'b0);
    end
    t = cyc;
    @(negedge clk);
    chk("ready_after_close", rdy_of(d), 0);
    while (!ov_of(d) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("latency", cyc - t, (d == 4) ? 5 : 4);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((q4.size() != 0 || q3.size() != 0 || ov4 || ov3) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", w < 200 ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", rdy4, 1);
    chk("rst_out_valid", ov4, 0);
    chk("rst_out_label", ol4, 0);
    chk("rst_out_votes", ovt4, 0);
    chk("rst_out_tie_bad", {tie4, bad4}, 0);
    rst = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("init_in_ready", rdy4, 1);
    chk("init_out_valid", ov4, 0);
    chk("init_outs", {ol4, ovt4, tie4, bad4}, 0);
    chk("init3_in_ready", rdy3, 1);
    rst = 1'b1;

    // Plain majority, closes on 5th vote with in_last
    run_vec(4, {2'd2, 2'd1, 2'd2, 2'd3, 2'd2}, 5, 1, '{label: 2'd2, votes: 3'd3, tie: 1'b0, bad: 1'b0});
    wait_drain();
    // Tie resolves to lowest label
    run_vec(4, {2'd3, 2'd1, 2'd3, 2'd1, 2'd0}, 5, 1, '{label: 2'd1, votes: 3'd2, tie: 1'b1, bad: 1'b0});
    wait_drain();
    // Early end after two votes
    run_vec(4, {2'd3, 2'd3, 6'd0}, 2, 1, '{label: 2'd3, votes: 3'd2, tie: 1'b0, bad: 1'b0});
    wait_drain();
    // Five votes without in_last close automatically
    run_vec(4, {2'd0, 2'd0, 2'd1, 2'd1, 2'd1}, 5, 0, '{label: 2'd1, votes: 3'd3, tie: 1'b0, bad: 1'b0});
    wait_drain();

    // Backpressure: hold out_ready low for 10 cycles in DONE
    @(posedge clk);
    #1 ordy4 = 1'b0;
    run_vec(4, {2'd0, 2'd0, 2'd0, 2'd2, 2'd2}, 5, 1, '{label: 2'd0, votes: 3'd3, tie: 1'b0, bad: 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", rdy4, 0);
      chk("bp_out_valid", ov4, 1);
    end
    @(posedge clk);
    #1 ordy4 = 1'b1;
    wait_drain();
    // Next decision must see a cleared histogram
    run_vec(4, {2'd1, 8'd0}, 1, 1, '{label: 2'd1, votes: 3'd1, tie: 1'b0, bad: 1'b0});
    wait_drain();

    // Three-class instance: out-of-range labels
    run_vec(3, {2'd3, 2'd3, 2'd3, 2'd0, 2'd1}, 5, 1, '{label: 2'd0, votes: 3'd1, tie: 1'b1, bad: 1'b1});
    wait_drain();
    run_vec(3, {2'd2, 2'd1, 2'd2, 2'd3, 2'd2}, 5, 1, '{label: 2'd2, votes: 3'd3, tie: 1'b0, bad: 1'b1});
    wait_drain();
    run_vec(3, {2'd3, 2'd3, 6'd0}, 2, 1, '{label: 2'd0, votes: 3'd0, tie: 1'b1, bad: 1'b1});
    wait_drain();
    // Bad flag must not carry into a clean decision
    run_vec(3, {2'd1, 2'd1, 6'd0}, 2, 1, '{label: 2'd1, votes: 3'd2, tie: 1'b0, bad: 1'b0});
    wait_drain();

    // Reset mid-ACCUM after two votes
    send(4, 2'd2, 1'b0);
    send(4, 2'd2, 1'b0);
    do_reset();
    // Reset mid-SCAN
    send(4, 2'd2, 1'b0);
    send(4, 2'd2, 1'b0);
    send(4, 2'd2, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_partial_out", ov4, 0);
    end
    // Full decision afterwards with no carry-over
    run_vec(4, {2'd0, 2'd1, 2'd1, 2'd3, 2'd0}, 5, 1, '{label: 2'd0, votes: 3'd2, tie: 1'b1, bad: 1'b0});
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
